// File: rtl/multicycle_alu.sv
// multicycle_alu: three-state ALU with single-cycle ops, shift-add multiply and restoring divide
module multicycle_alu #(
    parameter int WIDTH = 32,
    parameter int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [2:0]       opSwitch,
    input  logic [2:0]       flagSwitch,
    input  logic [SHW-1:0]   shamt,
    input  logic             isLog,
    input  logic             dir,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] rem,
    output logic             flag
);
    localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2;
    logic [1:0] state;
    logic [WIDTH-1:0] x, y, acc, shifted, mul_acc, div_rem, div_quo, res_n, rem_n;
    logic [WIDTH:0] sum, part, diff;
    logic [2:0] op, fsel;
    logic [SHW-1:0] sh, cnt;
    logic is_log, dir_r, div0, iter, last, ovf, flag_n;
    always_comb begin
        sum = {1'b0, x} + {1'b0, y};
        ovf = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
        shifted = !dir_r ? x << sh : is_log ? x >> sh : $unsigned($signed(x) >>> sh);
        mul_acc = acc + (x[0] ? y : '0);
        part = {acc, x[WIDTH-1]};
        diff = part - {1'b0, y};
        div_rem = diff[WIDTH] ? part[WIDTH-1:0] : diff[WIDTH-1:0];
        div_quo = {x[WIDTH-2:0], ~diff[WIDTH]};
        div0 = op == 3'd6 && y == '0;
        iter = (op == 3'd5 || op == 3'd6) && !div0;
        last = !iter || cnt == SHW'(WIDTH - 1);
        res_n = op == 3'd0 ? sum[WIDTH-1:0] :
                op == 3'd1 ? -y :
                op == 3'd2 ? x & y :
                op == 3'd3 ? x ^ y :
                op == 3'd4 ? shifted :
                op == 3'd5 ? mul_acc :
                op == 3'd6 ? (div0 ? '1 : div_quo) : '0;
        rem_n = op != 3'd6 ? '0 : div0 ? x : div_rem;
        flag_n = fsel == 3'd0 ? res_n == '0 :
                 fsel == 3'd1 ? op == 3'd0 && sum[WIDTH] :
                 fsel == 3'd2 ? res_n[WIDTH-1] :
                 fsel == 3'd3 ? op == 3'd0 && ovf :
                 fsel == 3'd4 && div0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            result <= '0;
            rem <= '0;
            flag <= 1'b0;
            cnt <= '0;
            acc <= '0;
        end else if (state == IDLE && start) begin
            state <= EXEC;
            x <= data1;
            y <= data2;
            op <= opSwitch;
            fsel <= flagSwitch;
            sh <= shamt;
            is_log <= isLog;
            dir_r <= dir;
            acc <= '0;
            cnt <= '0;
        end else if (state == EXEC) begin
            cnt <= cnt + 1'b1;
            if (op == 3'd5) begin
                acc <= mul_acc;
                x <= x >> 1;
                y <= y << 1;
            end else if (op == 3'd6) begin
                acc <= div_rem;
                x <= div_quo;
            end
            if (last) begin
                state <= DONE;
                result <= res_n;
                rem <= rem_n;
                flag <= flag_n;
            end
        end else if (state == DONE) begin
            state <= IDLE;
        end
    end
    assign busy = state != IDLE;
    assign done = state == DONE;
endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: directed scoreboard bench for multicycle_alu at WIDTH=32
module tb_multicycle_alu;
    logic clk = 0, rst = 1, start = 0, isLog = 0, dir = 0;
    logic [31:0] data1 = 0, data2 = 0;
    logic [2:0] opSwitch = 0, flagSwitch = 0;
    logic [4:0] shamt = 0;
    logic busy, done, flag;
    logic [31:0] result, rem;
    int errors = 0, checks = 0, cyc = 0, t0 = 0;
    typedef struct {logic [31:0] r; logic [31:0] m; logic f; int lat;} exp_t;
    exp_t q[$];

    multicycle_alu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .data1(data1), .data2(data2),
        .opSwitch(opSwitch), .flagSwitch(flagSwitch), .shamt(shamt), .isLog(isLog),
        .dir(dir), .busy(busy), .done(done), .result(result), .rem(rem), .flag(flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // called at a falling edge; inputs are scrambled after acceptance
    task automatic send(input logic [2:0] op, input logic [2:0] fs, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] s, input logic il, input logic d,
                        input logic [31:0] er, input logic [31:0] em, input logic ef, input int lat);
        q.push_back('{er, em, ef, lat});
        data1 = a; data2 = b; opSwitch = op; flagSwitch = fs; shamt = s; isLog = il; dir = d;
        start = 1; t0 = cyc;
        @(negedge clk);
        start = 0; data1 = $urandom; data2 = $urandom; opSwitch = 3'($urandom);
        flagSwitch = 3'($urandom); shamt = 5'($urandom); isLog = 1'($urandom); dir = 1'($urandom);
    endtask

    task automatic expect_done(input string tag, input int budget);
        exp_t e;
        logic seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk); #1;
            seen = done;
        end
        if (!seen) begin
            chk({tag, "_timeout"}, 32'(done), 1);
            if (q.size() > 0) void'(q.pop_front());
        end else begin
            e = q.pop_front();
            chk({tag, "_lat"}, 32'(cyc - t0), 32'(e.lat));
            chk({tag, "_result"}, result, e.r);
            chk({tag, "_rem"}, rem, e.m);
            chk({tag, "_flag"}, 32'(flag), 32'(e.f));
            @(posedge clk); #1;
            chk({tag, "_pulse"}, 32'(done), 0);
        end
        @(negedge clk);
    endtask

    task automatic no_done(input string tag, input int n);
        logic seen = 0;
        repeat (n) begin
            @(posedge clk); #1;
            seen |= done;
        end
        chk(tag, 32'(seen), 0);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] a, b, p;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_result", result, 0);
        chk("rst_rem", rem, 0);
        chk("rst_flag", 32'(flag), 0);
        rst = 0;
        send(0, 2, 20, 10, 0, 0, 0, 30, 0, 0, 2); expect_done("add", 10);
        send(4, 2, 987, 0, 3, 1, 1, 123, 0, 0, 2); expect_done("shr_log", 10);
        send(4, 2, 32'h80000000, 0, 4, 0, 1, 32'hF8000000, 0, 1, 2); expect_done("shr_arith", 10);
        send(4, 0, 32'h80000001, 0, 1, 0, 0, 2, 0, 0, 2); expect_done("shl", 10);
        send(4, 0, 32'h1234, 0, 0, 0, 1, 32'h1234, 0, 0, 2); expect_done("shift0", 10);
        send(1, 2, 0, 5, 0, 0, 0, 32'hFFFFFFFB, 0, 1, 2); expect_done("neg", 10);
        send(2, 0, 32'hF0F0F0F0, 32'h0F0F0F0F, 0, 0, 0, 0, 0, 1, 2); expect_done("and", 10);
        send(3, 2, 32'hF0F0F0F0, 32'h0F0F0F0F, 0, 0, 0, 32'hFFFFFFFF, 0, 1, 2); expect_done("xor", 10);
        send(7, 0, 12, 34, 0, 0, 0, 0, 0, 1, 2); expect_done("rsvd", 10);
        send(2, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 32'hFFFFFFFF, 0, 0, 2); expect_done("carry_nonadd", 10);
        send(0, 3, 32'h7FFFFFFF, 1, 0, 0, 0, 32'h80000000, 0, 1, 2); expect_done("add_ovf", 10);
        send(0, 1, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0, 1, 2); expect_done("add_carry", 10);
        send(0, 3, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0, 0, 2); expect_done("add_noovf", 10);
        send(5, 0, 1000, 3, 0, 0, 0, 3000, 0, 0, 33);
        repeat (5) @(negedge clk);
        chk("mul_busy", 32'(busy), 1);
        start = 1; opSwitch = 0; data1 = 1; data2 = 1;
        @(negedge clk);
        start = 0;
        expect_done("mul", 60);
        no_done("mul_extra_done", 40);
        send(6, 0, 100, 7, 0, 0, 0, 14, 2, 0, 33); expect_done("div", 60);
        send(6, 4, 5, 0, 0, 0, 0, 32'hFFFFFFFF, 5, 1, 2); expect_done("div0", 10);
        send(6, 0, 3, 10, 0, 0, 0, 0, 3, 1, 33); expect_done("div_small", 60);
        for (int i = 0; i < 3; i++) begin
            a = $urandom; b = 32'($urandom_range(1, 65535)); p = a * b;
            send(5, 2, a, b, 0, 0, 0, p, 0, p[31], 33); expect_done("mul_rand", 60);
            p = a / b;
            send(6, 2, a, b, 0, 0, 0, p, a % b, p[31], 33); expect_done("div_rand", 60);
        end
        data1 = 1000; data2 = 3; opSwitch = 5; flagSwitch = 0; start = 1;
        @(negedge clk);
        start = 0;
        repeat (9) @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_result", result, 0);
        chk("abort_rem", rem, 0);
        chk("abort_flag", 32'(flag), 0);
        rst = 0;
        no_done("abort_no_done", 40);
        send(0, 0, 2, 3, 0, 0, 0, 5, 0, 0, 2); expect_done("add_after_abort", 10);
        rst = 1; start = 1; opSwitch = 0; data1 = 1; data2 = 1;
        @(negedge clk);
        rst = 0; start = 0;
        @(posedge clk); #1;
        chk("start_with_rst_busy", 32'(busy), 0);
        @(negedge clk);
        no_done("start_with_rst_done", 5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 Parameter WIDTH, default 32; operand, result and remainder width in bits; legal values 8, 16, 32, 64.
REQ-002 Parameter SHW, default $clog2(WIDTH); width of shamt.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request strobe; sampled only in IDLE.
REQ-006 data1  input  WIDTH  operand A.
REQ-007 data2  input  WIDTH  operand B.
REQ-008 opSwitch  input  3  operation select.
REQ-009 flagSwitch  input  3  flag source select.
REQ-010 shamt  input  SHW  shift amount.
REQ-011 isLog  input  1  1 = logical right shift, 0 = arithmetic right shift.
REQ-012 dir  input  1  0 = shift left, 1 = shift right.
REQ-013 busy  output  1  high while a request is executing.
REQ-014 done  output  1  one-cycle pulse when result and flag are valid.
REQ-015 result  output  WIDTH  registered result.
REQ-016 rem  output  WIDTH  registered remainder; valid for divide only, 0 otherwise.
REQ-017 flag  output  1  registered flag selected by flagSwitch.

Function
REQ-018 States: IDLE, EXEC, DONE. IDLE->EXEC on start; EXEC->DONE when the operation completes; DONE->IDLE unconditionally after one cycle.
REQ-019 Accept: start=1 in IDLE captures data1, data2, opSwitch, flagSwitch, shamt, isLog and dir; later input changes do not affect the request.
REQ-020 start while busy=1 or in DONE is ignored, with no queuing.
REQ-021 busy=1 in EXEC and DONE; done=1 only in DONE.
REQ-022 Ops: 0 add; 1 two's-complement negate of B; 2 A AND B; 3 A XOR B; 4 shift A by shamt per dir/isLog; 5 unsigned multiply, low WIDTH bits; 6 unsigned divide, result=quotient, rem=remainder; 7 reserved, result=0.
REQ-023 Ops 0-4 and 7: one EXEC cycle; start accepted at edge N -> done high in cycle N+2.
REQ-024 Op 5: iterative shift-add, one bit per cycle, WIDTH EXEC cycles; done high in cycle N+WIDTH+1.
REQ-025 Op 6: restoring division, one bit per cycle, WIDTH EXEC cycles; same latency as op 5.
REQ-026 Divide by zero (B=0 captured): one EXEC cycle; result all ones, rem=A.
REQ-027 Add is modulo 2^WIDTH; carry is bit WIDTH of the unsigned sum; overflow is set when operand signs match and the result sign differs.
REQ-028 Left shift is logical regardless of isLog; shamt=0 returns A unchanged.
REQ-029 flagSwitch: 0 zero (result==0); 1 carry (op 0 only, else 0); 2 sign (result MSB); 3 overflow (op 0 only, else 0); 4 divide-by-zero (op 6 only); 5-7 give 0.
REQ-030 result, rem and flag update together on entry to DONE and hold until the next completion or reset.
REQ-031 Multiply high-order product bits are discarded; no flag reports multiply overflow.

Reset
REQ-032 rst=1 at any edge forces IDLE; busy=0, done=0, result=0, rem=0, flag=0; internal iteration counters clear.
REQ-033 rst during EXEC aborts the operation; done does not pulse for the aborted request.
REQ-034 start asserted together with rst is ignored.
REQ-035 First start is accepted at the first edge after rst deasserts.

Verification (WIDTH=32)
REQ-036 add 20+10, flagSwitch=2 -> result=30, flag=0, done two cycles after start.
REQ-037 op 4, data1=987, dir=1, isLog=1, shamt=3 -> result=123; data1=0x80000000, isLog=0, shamt=4 -> result=0xF8000000.
REQ-038 mul 1000*3 -> result=3000, done at cycle N+33; second start issued during busy produces no extra done.
REQ-039 div 100/7 -> result=14, rem=2, latency 33; div 5/0, flagSwitch=4 -> result=0xFFFFFFFF, rem=5, flag=1, latency 2.
REQ-040 add 0x7FFFFFFF+1, flagSwitch=3 -> flag=1; add 0xFFFFFFFF+1, flagSwitch=1 -> result=0, flag=1.
REQ-041 rst at cycle 10 of a multiply -> busy=0 next cycle, outputs 0, no done; a new add completes normally.
